// File: rtl/data_memory_be.sv
// Byte-enabled 32-bit data memory with RV32 load/store width handling,
// a one-cycle registered response and an optional zero-fill sweep after reset.
module data_memory_be #(
   parameter int DEPTH_WORDS = 256,
   parameter bit CLR_ON_RST  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        fault,
   output logic        busy,
   output logic [31:0] dm0
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

   typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

   state_t        state_r;
   logic [AW-1:0] cnt_r;
   logic [31:0]   mem_r [DEPTH_WORDS];

   logic [AW-1:0] idx_s;
   logic          accept_s;
   logic          fault_s;
   logic          wr_s;
   logic [3:0]    be_s;
   logic [31:0]   wd_s;
   logic [31:0]   ld_s;
   logic          unused_s;

   // Misalignment, reserved width codes and unsigned-store codes all fault.
   function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b000:  is_fault = 1'b0;
         3'b001:  is_fault = a[0];
         3'b010:  is_fault = (a != 2'b00);
         3'b100:  is_fault = we;
         3'b101:  is_fault = we | a[0];
         default: is_fault = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b000:  store_be = 4'b0001 << a;
         3'b001:  store_be = a[1] ? 4'b1100 : 4'b0011;
         3'b010:  store_be = 4'b1111;
         default: store_be = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  load_ext = {{24{b[7]}}, b};
         3'b001:  load_ext = {{16{h[15]}}, h};
         3'b010:  load_ext = w;
         3'b100:  load_ext = {24'h000000, b};
         3'b101:  load_ext = {16'h0000, h};
         default: load_ext = 32'h00000000;
      endcase
   endfunction

   // Request decode: lanes, replicated store data and extended load value.
   always_comb begin
      idx_s    = addr[AW+1:2];
      accept_s = req_valid & (state_r == ST_IDLE);
      fault_s  = is_fault(req_we, funct3, addr[1:0]);
      wr_s     = accept_s & req_we & ~fault_s & ~rst;
      be_s     = store_be(funct3, addr[1:0]);
      case (funct3)
         3'b000:  wd_s = {4{wdata[7:0]}};
         3'b001:  wd_s = {2{wdata[15:0]}};
         default: wd_s = wdata;
      endcase
      ld_s     = load_ext(funct3, addr[1:0], mem_r[idx_s]);
      unused_s = ^addr[31:AW+2];
   end

   // Storage array; the sweep and accepted stores are the only writers, rst never touches it.
   always_ff @(posedge clk) begin
      if (!rst && state_r == ST_CLEAR) begin
         mem_r[cnt_r] <= 32'h00000000;
      end else if (wr_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) mem_r[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
         end
      end
   end

   // Control FSM plus registered response; every accepted request answers next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
         cnt_r       <= '0;
         rdata       <= 32'h00000000;
         rdata_valid <= 1'b0;
         fault       <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         fault       <= 1'b0;
         case (state_r)
            ST_CLEAR: begin
               cnt_r <= cnt_r + 1'b1;
               if (cnt_r == LAST_IDX) state_r <= ST_IDLE;
            end
            ST_IDLE: begin
               if (req_valid) begin
                  rdata_valid <= 1'b1;
                  fault       <= fault_s;
                  rdata       <= (fault_s | req_we) ? 32'h00000000 : ld_s;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state_r == ST_CLEAR);
   assign dm0  = mem_r[0];

endmodule

// File: tb/tb_data_memory_be.sv
// Self-checking bench for data_memory_be: vector table through a response
// scoreboard, plus reset / clear-sweep sequences.
module tb_data_memory_be;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        fault;
   logic        busy;
   logic [31:0] dm0;

   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

   always #5 clk = ~clk;

   data_memory_be #(.DEPTH_WORDS(256), .CLR_ON_RST(1'b1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
      .fault(fault), .busy(busy), .dm0(dm0)
   );

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      logic [31:0] exp_dm0;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          tag;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ef,
                      input logic [31:0] ed);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
      v.exp_rdata = er; v.exp_fault = ef; v.exp_dm0 = ed;
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
   endtask

   // Waits until busy drops; n = edges taken while busy was observed high.
   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Response monitor on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rdata_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid actual=rdata_valid=1 required=rdata_valid=0");
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               if (rdata !== e.rdata || fault !== e.fault) begin
                  errors++;
                  $display("FAIL resp_%0d actual=rdata 0x%08h fault %b required=rdata 0x%08h fault %b",
                           e.tag, rdata, fault, e.rdata, e.fault);
               end
            end
         end else begin
            checks++;
            if (fault !== 1'b0) begin
               errors++;
               $display("FAIL fault_unqualified actual=%b required=0", fault);
            end
         end
      end
   end

   initial begin
      int n;
      idle_inputs();
      rst = 1'b1;

      // After sweep every word is zero; dm0 tracks word 0 through the table.
      add(1'b1, F_W,  32'h10,  32'h80FF7F01, 32'h00000000, 1'b0, 32'h00000000);
      add(1'b0, F_B,  32'h10,  32'h0,        32'h00000001, 1'b0, 32'h00000000);
      add(1'b0, F_BU, 32'h13,  32'h0,        32'h00000080, 1'b0, 32'h00000000);
      add(1'b0, F_B,  32'h13,  32'h0,        32'hFFFFFF80, 1'b0, 32'h00000000);
      add(1'b0, F_H,  32'h12,  32'h0,        32'hFFFF80FF, 1'b0, 32'h00000000);
      add(1'b0, F_HU, 32'h12,  32'h0,        32'h000080FF, 1'b0, 32'h00000000);
      add(1'b0, F_W,  32'h10,  32'h0,        32'h80FF7F01, 1'b0, 32'h00000000);
      add(1'b0, F_H,  32'h10,  32'h0,        32'h00007F01, 1'b0, 32'h00000000);
      add(1'b0, F_BU, 32'h11,  32'h0,        32'h0000007F, 1'b0, 32'h00000000);
      add(1'b0, F_B,  32'h12,  32'h0,        32'hFFFFFFFF, 1'b0, 32'h00000000);
      add(1'b1, F_W,  32'h0,   32'h11223344, 32'h00000000, 1'b0, 32'h11223344);
      add(1'b1, F_B,  32'h2,   32'h123456AA, 32'h00000000, 1'b0, 32'h11AA3344);
      add(1'b0, F_W,  32'h0,   32'h0,        32'h11AA3344, 1'b0, 32'h11AA3344);
      add(1'b1, F_H,  32'h2,   32'hDEADBEEF, 32'h00000000, 1'b0, 32'hBEEF3344);
      add(1'b0, F_W,  32'h0,   32'h0,        32'hBEEF3344, 1'b0, 32'hBEEF3344);
      add(1'b1, F_W,  32'h6,   32'h55555555, 32'h00000000, 1'b1, 32'hBEEF3344);
      add(1'b0, F_H,  32'h3,   32'h0,        32'h00000000, 1'b1, 32'hBEEF3344);
      add(1'b0, 3'b011, 32'h0, 32'h0,        32'h00000000, 1'b1, 32'hBEEF3344);
      add(1'b1, F_BU, 32'h0,   32'h00000077, 32'h00000000, 1'b1, 32'hBEEF3344);
      add(1'b1, F_HU, 32'h0,   32'h00007777, 32'h00000000, 1'b1, 32'hBEEF3344);
      add(1'b1, 3'b111, 32'h0, 32'h66666666, 32'h00000000, 1'b1, 32'hBEEF3344);
      add(1'b0, F_W,  32'h4,   32'h0,        32'h00000000, 1'b0, 32'hBEEF3344);
      add(1'b0, F_W,  32'h0,   32'h0,        32'hBEEF3344, 1'b0, 32'hBEEF3344);
      add(1'b1, F_H,  32'h14,  32'hFFFF1234, 32'h00000000, 1'b0, 32'hBEEF3344);
      add(1'b1, F_B,  32'h15,  32'h00000056, 32'h00000000, 1'b0, 32'hBEEF3344);
      add(1'b0, F_W,  32'h14,  32'h0,        32'h00005634, 1'b0, 32'hBEEF3344);
      add(1'b1, F_W,  32'h400, 32'hCAFEF00D, 32'h00000000, 1'b0, 32'hCAFEF00D);
      add(1'b0, F_W,  32'h0,   32'h0,        32'hCAFEF00D, 1'b0, 32'hCAFEF00D);
      add(1'b0, F_HU, 32'h1,   32'h0,        32'h00000000, 1'b1, 32'hCAFEF00D);
      add(1'b0, 3'b110, 32'h0, 32'h0,        32'h00000000, 1'b1, 32'hCAFEF00D);
      add(1'b0, F_W,  32'h402, 32'h0,        32'h00000000, 1'b1, 32'hCAFEF00D);
      add(1'b0, F_W,  32'h400, 32'h0,        32'hCAFEF00D, 1'b0, 32'hCAFEF00D);

      // Reset state and initial clear sweep.
      @(posedge clk); #1;
      @(posedge clk); #1;
      mon_en = 1'b1;
      check32("rst_rdata", rdata, 32'h0);
      check32("rst_rdata_valid", {31'h0, rdata_valid}, 32'h0);
      check32("rst_fault", {31'h0, fault}, 32'h0);
      check32("rst_busy", {31'h0, busy}, 32'h1);
      rst = 1'b0;
      count_busy(n);
      check32("sweep_cycles", n, 32'd256);
      check32("dm0_after_sweep", dm0, 32'h0);

      // Table: one request per cycle, back to back.
      for (int i = 0; i < vecs.size(); i++) begin
         exp_t e;
         req_valid = 1'b1; req_we = vecs[i].we; funct3 = vecs[i].f3;
         addr = vecs[i].addr; wdata = vecs[i].wdata;
         e.rdata = vecs[i].exp_rdata; e.fault = vecs[i].exp_fault; e.tag = i;
         sb_q.push_back(e);
         @(posedge clk); #1;
         check32($sformatf("dm0_%0d", i), dm0, vecs[i].exp_dm0);
      end
      idle_inputs();
      @(posedge clk); #1;

      // rst together with a load: request dropped, rdata cleared, sweep restarts.
      req_valid = 1'b1; req_we = 1'b0; funct3 = F_W; addr = 32'h0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check32("rst_mid_rdata", rdata, 32'h0);
      check32("rst_mid_busy", {31'h0, busy}, 32'h1);

      // Loads issued during the sweep must be ignored; restart at sweep cycle 100.
      for (int c = 0; c < 100; c++) begin
         addr = {20'h0, 10'(c), 2'b00};
         @(posedge clk); #1;
      end
      check32("busy_at_100", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      count_busy(n);
      check32("restart_sweep_cycles", n, 32'd256);
      idle_inputs();
      check32("dm0_after_restart", dm0, 32'h0);

      // Memory cleared again by the restarted sweep.
      begin
         exp_t e;
         req_valid = 1'b1; req_we = 1'b0; funct3 = F_W; addr = 32'h14;
         e.rdata = 32'h0; e.fault = 1'b0; e.tag = 100;
         sb_q.push_back(e);
         @(posedge clk); #1;
         addr = 32'h10; e.tag = 101;
         sb_q.push_back(e);
         @(posedge clk); #1;
         idle_inputs();
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      check32("scoreboard_drained", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
